regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter BW_DATA, default 16, entry data width in bits.
REQ-002 SHALL have parameter BW_ADDR, default 4, address width; depth is 2**BW_ADDR.
REQ-003 SHALL have parameter N_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter N_WR, default 2, number of write ports (1..4).
REQ-005 SHALL have parameter RD_LAT, default 0: 0 = combinational read, 1 = registered read.
REQ-006 SHALL have parameter BYPASS, default 1: 1 = write-to-read forwarding in the same cycle.
REQ-007 SHALL have parameter ZERO_REG, default 0: 1 = address 0 is hard-wired to zero.
REQ-008 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-009 SHALL have port i_rstn  input  1  reset; synchronous and active-low.
REQ-010 SHALL have port i_rf_rd_addr  input  N_RD*BW_ADDR  packed read addresses; port k is in slice k.
REQ-011 SHALL have port i_rf_rd_en  input  N_RD  per-port read capture enable; used only when RD_LAT=1.
REQ-012 SHALL have port o_rf_rd_data  output  N_RD*BW_DATA  packed read data; port k is in slice k.
REQ-013 SHALL have port i_rf_wr_addr  input  N_WR*BW_ADDR  packed write addresses.
REQ-014 SHALL have port i_rf_wr_data  input  N_WR*BW_DATA  packed write data.
REQ-015 SHALL have port i_rf_wr_en  input  N_WR  per-port write enable.
REQ-016 SHALL have port i_rf_clr  input  1  single-cycle request to start a clear sweep.
REQ-017 SHALL have port o_rf_busy  output  1  high while the clear sweep runs.
REQ-018 SHALL have port o_rf_wr_conflict  output  1  registered pulse: two or more enabled write ports hit the same address.

Function
REQ-019 SHALL write i_rf_wr_data[w] into entry i_rf_wr_addr[w] on the rising edge when i_rf_wr_en[w]=1 and o_rf_busy=0.
REQ-020 SHALL give priority to the highest-index write port when several enabled ports target the same address in one cycle.
REQ-021 SHALL assert o_rf_wr_conflict for exactly one cycle, the cycle after the colliding writes.
REQ-022 SHALL return the addressed entry combinationally on o_rf_rd_data when RD_LAT=0.
REQ-023 SHALL, when RD_LAT=1, register the addressed value on a rising edge with i_rf_rd_en[k]=1, and hold the previous value otherwise (1-cycle latency).
REQ-024 SHALL, when BYPASS=1, present the winning same-cycle write data on a read of the same address, in both read modes.
REQ-025 SHALL, when BYPASS=0, present the pre-write contents on a same-cycle read of the written address.
REQ-026 SHALL, when ZERO_REG=1, always read address 0 as zero, ignore writes to it, and exclude it from conflict detection.
REQ-027 SHALL implement the clear FSM with two states:
- IDLE -> CLEAR on i_rf_clr=1, with sweep pointer set to 0.
- CLEAR writes 0 to entry[ptr] each cycle, then increments ptr.
- CLEAR -> IDLE after writing entry 2**BW_ADDR-1; the sweep takes exactly 2**BW_ADDR cycles.
REQ-028 SHALL assert o_rf_busy=1 exactly while in CLEAR.
REQ-029 SHALL discard all port writes while in CLEAR, and SHALL NOT flag them as conflicts.
REQ-030 SHALL serve reads normally during CLEAR, returning current (partially cleared) contents.
REQ-031 SHALL ignore i_rf_clr asserted while already in CLEAR.
REQ-032 SHALL wrap each port address modulo depth, with no out-of-range behaviour.

Reset
REQ-033 SHALL, on a rising edge with i_rstn=0, zero all entries, zero the RD_LAT=1 read registers, set FSM to IDLE, set ptr=0, and clear o_rf_wr_conflict.
REQ-034 SHALL, on reset during CLEAR, abort the sweep; o_rf_busy=0 on the next cycle.
REQ-035 SHALL give reset precedence over simultaneous writes and i_rf_clr.

Structure
REQ-036 SHALL place the FSM state encoding (IDLE=0, CLEAR=1) and the RD_LAT mode constants in shared package regfile_pkg.
REQ-037 SHALL implement the clear FSM and sweep pointer in sub-module regfile_clr_fsm (outputs: busy, clear write enable, clear address).
REQ-038 SHALL hold storage, write arbitration, bypass and read ports in regfile_mp itself.

Verification (BW_DATA=16, BW_ADDR=4, N_RD=2, N_WR=2)
REQ-039 SHALL cover sequential fill and readback: write addr i = data i*0x1111 for i=0..15, then read pairs (i,15-i) -> exact values; with RD_LAT=1, data arrives one cycle after the read enable.
REQ-040 SHALL cover write conflict: port0 writes addr 5=0xAAAA and port1 writes addr 5=0x5555 in the same cycle -> entry 5 reads 0x5555; o_rf_wr_conflict=1 for one cycle only.
REQ-041 SHALL cover bypass: entry 3=0x1234, then write 3=0xBEEF while reading 3 in the same cycle -> BYPASS=1 gives 0xBEEF; BYPASS=0 gives 0x1234, then 0xBEEF next cycle.
REQ-042 SHALL cover clear sweep: pulse i_rf_clr -> o_rf_busy high exactly 16 cycles; a write of 0xFFFF to addr 9 mid-sweep is dropped; all entries read 0 afterward.
REQ-043 SHALL cover reset mid-sweep: i_rstn=0 at sweep cycle 6 -> next cycle o_rf_busy=0, all entries 0, o_rf_rd_data=0.
REQ-044 SHALL cover ZERO_REG=1: write addr 0=0x7777 on both ports -> addr 0 reads 0x0000 and o_rf_wr_conflict stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-FSM state encoding and read-latency mode constants
package regfile_pkg;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam int RD_COMB = 0;
    localparam int RD_REG  = 1;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/clear bundle of the multi-port register file
interface regfile_mp_if #(
    parameter int BW_DATA = 16,
    parameter int BW_ADDR = 4,
    parameter int N_RD    = 2,
    parameter int N_WR    = 2
);
    logic [N_RD*BW_ADDR-1:0] i_rf_rd_addr;
    logic [N_RD-1:0]         i_rf_rd_en;
    logic [N_RD*BW_DATA-1:0] o_rf_rd_data;
    logic [N_WR*BW_ADDR-1:0] i_rf_wr_addr;
    logic [N_WR*BW_DATA-1:0] i_rf_wr_data;
    logic [N_WR-1:0]         i_rf_wr_en;
    logic                    i_rf_clr;
    logic                    o_rf_busy;
    logic                    o_rf_wr_conflict;
    modport master (
        output i_rf_rd_addr, i_rf_rd_en, i_rf_wr_addr, i_rf_wr_data, i_rf_wr_en, i_rf_clr,
        input  o_rf_rd_data, o_rf_busy, o_rf_wr_conflict
    );
    modport slave (
        input  i_rf_rd_addr, i_rf_rd_en, i_rf_wr_addr, i_rf_wr_data, i_rf_wr_en, i_rf_clr,
        output o_rf_rd_data, o_rf_busy, o_rf_wr_conflict
    );
endinterface

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sweeps a zero through every entry, one per cycle, after a clear request
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int BW_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_clr,
    output logic               o_busy,
    output logic               o_clr_we,
    output logic [BW_ADDR-1:0] o_clr_addr
);
    logic [0:0]         state_q, state_d;
    logic [BW_ADDR-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_IDLE && i_clr) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
        end else if (state_q == ST_CLEAR) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = (ptr_q == {BW_ADDR{1'b1}}) ? ST_IDLE : ST_CLEAR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_busy     = (state_q == ST_CLEAR);
    assign o_clr_we   = o_busy;
    assign o_clr_addr = ptr_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write arbitration, optional forwarding,
// optional registered reads and a background clear sweep
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int BW_DATA  = 16,
    parameter int BW_ADDR  = 4,
    parameter int N_RD     = 2,
    parameter int N_WR     = 2,
    parameter int RD_LAT   = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input logic         i_clk,
    input logic         i_rstn,
    regfile_mp_if.slave rf
);
    localparam int DEPTH = 2**BW_ADDR;

    logic [BW_DATA-1:0] mem_q [DEPTH];
    logic [BW_DATA-1:0] mem_d [DEPTH];
    logic [BW_DATA-1:0] wr_d  [DEPTH];
    logic [BW_ADDR-1:0] wr_addr [N_WR];
    logic [BW_DATA-1:0] wr_data [N_WR];
    logic [N_WR-1:0]    wr_ok;
    logic               conflict_q, conflict_d;
    logic               busy, clr_we;
    logic [BW_ADDR-1:0] clr_addr;

    regfile_clr_fsm #(.BW_ADDR(BW_ADDR)) u_clr_fsm (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_clr      (rf.i_rf_clr),
        .o_busy     (busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    // A port write is effective only outside the sweep and never to a hard-wired zero entry
    for (genvar w = 0; w < N_WR; w++) begin : g_wr
        assign wr_addr[w] = rf.i_rf_wr_addr[w*BW_ADDR +: BW_ADDR];
        assign wr_data[w] = rf.i_rf_wr_data[w*BW_DATA +: BW_DATA];
        assign wr_ok[w]   = rf.i_rf_wr_en[w] && !busy && !(ZERO_REG != 0 && wr_addr[w] == '0);
    end

    // wr_d holds port writes only (higher port wins); it is the forwarding source
    always_comb begin
        wr_d = mem_q;
        for (int w = 0; w < N_WR; w++)
            if (wr_ok[w]) wr_d[wr_addr[w]] = wr_data[w];
        mem_d = wr_d;
        if (clr_we) mem_d[clr_addr] = '0;
        conflict_d = 1'b0;
        for (int i = 0; i < N_WR; i++)
            for (int j = i + 1; j < N_WR; j++)
                if (wr_ok[i] && wr_ok[j] && wr_addr[i] == wr_addr[j]) conflict_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            mem_q      <= '{default: '0};
            conflict_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            conflict_q <= conflict_d;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [BW_ADDR-1:0] rd_addr;
        logic [BW_DATA-1:0] rd_val, rd_q, rd_d;
        assign rd_addr = rf.i_rf_rd_addr[k*BW_ADDR +: BW_ADDR];
        assign rd_val  = (ZERO_REG != 0 && rd_addr == '0) ? '0 :
                         (BYPASS != 0) ? wr_d[rd_addr] : mem_q[rd_addr];
        assign rd_d    = rf.i_rf_rd_en[k] ? rd_val : rd_q;
        always_ff @(posedge i_clk) begin
            if (!i_rstn) rd_q <= '0;
            else         rd_q <= rd_d;
        end
        assign rf.o_rf_rd_data[k*BW_DATA +: BW_DATA] = (RD_LAT == RD_REG) ? rd_q : rd_val;
    end

    assign rf.o_rf_busy        = busy;
    assign rf.o_rf_wr_conflict = conflict_q;
endmodule
